// File: rtl/duck_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : duck_pkg                                               |
// | Description : Shared game-state encoding, fire FSM state type and    |
// |               default timing constants (also used by video flash).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package duck_pkg;

  // Game state as driven by the top-level game sequencer
  typedef logic [2:0] game_state_t;
  localparam game_state_t GS_PLAY = 3'd1;

  // Trigger fire FSM states
  typedef enum logic [1:0] {
    FS_IDLE         = 2'd0,
    FS_FLASH        = 2'd1,
    FS_COOLDOWN     = 2'd2,
    FS_RELEASE_WAIT = 2'd3
  } fire_state_t;

  // Default timing at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;    // 10 ms
  localparam int DEFAULT_FLASH_CYCLES    = 833333;    // one 60 Hz frame
  localparam int DEFAULT_COOLDOWN_CYCLES = 12500000;  // 0.25 s

  // Largest of three values, used to size a shared counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : trigger_debounce                                       |
// | Description : Two-flop synchroniser for the active-low trigger key   |
// |               plus a stable-run counter producing a debounced level. |
// |               db_valid marks that db has been confirmed at least     |
// |               once since reset.                                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module trigger_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic trigger_n,
  output logic db,
  output logic db_valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync_q;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          r_db_valid;
  logic [CW:0]   w_run;
  logic          w_settled;

  // Length of the current stable run, including this cycle
  assign w_run     = (r_sync2 == r_sync_q) ? ({1'b0, r_cnt} + (CW+1)'(1)) : (CW+1)'(1);
  assign w_settled = (w_run >= (CW+1)'(DEBOUNCE_CYCLES));

  // Bring the inverted key into the clock domain and remember last value
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync1  <= ~trigger_n;
      r_sync2  <= r_sync1;
      r_sync_q <= r_sync2;
    end
  end

  // Count stable cycles (saturating) and adopt the level once settled
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt      <= '0;
      r_db       <= 1'b0;
      r_db_valid <= 1'b0;
    end else begin
      r_cnt <= w_settled ? CW'(DEBOUNCE_CYCLES) : w_run[CW-1:0];
      if (w_settled) begin
        r_db       <= r_sync2;
        r_db_valid <= 1'b1;
      end
    end
  end

  assign db       = r_db;
  assign db_valid = r_db_valid;

endmodule
`default_nettype wire

// File: rtl/trigger_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : trigger_ctrl                                           |
// | Description : Light-gun trigger conditioning: debounce, game-state / |
// |               ammo gating, shot pulse, muzzle-flash window and       |
// |               cooldown. Optional macro TRIGGER_AUTO_FIRE_EN makes a  |
// |               held trigger repeat-fire at the end of each cooldown.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module trigger_ctrl
  import duck_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FLASH_CYCLES    = DEFAULT_FLASH_CYCLES,
  parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        trigger_n,
  input  game_state_t state,
  input  logic        no_shots_left,
  output logic        shot,
  output logic        flash_active,
  output logic        dry_fire,
  output logic        busy
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, FLASH_CYCLES, COOLDOWN_CYCLES);
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] c_FLASH_LAST = CW'(FLASH_CYCLES - 1);
  localparam logic [CW-1:0] c_COOL_LAST  = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [CW-1:0] c_CNT_SAT    = '1;

  logic          w_db;
  logic          w_db_valid;
  logic          w_press;
  logic          w_play;

  fire_state_t   r_fsm;
  logic [CW-1:0] r_cnt;
  logic          r_db_q;
  logic          r_armed;
  logic          r_shot;
  logic          r_flash;
  logic          r_dry;
  logic          r_busy;

  trigger_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clk       (Clk),
    .Reset     (Reset),
    .trigger_n (trigger_n),
    .db        (w_db),
    .db_valid  (w_db_valid)
  );

  // A press only counts once a confirmed release has been seen since reset,
  // so a trigger held through reset cannot fire on its own.
  assign w_press = w_db & ~r_db_q & r_armed;
  assign w_play  = (state == GS_PLAY);

  // Fire FSM with shared saturating counter and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fsm   <= FS_IDLE;
      r_cnt   <= '0;
      r_db_q  <= 1'b0;
      r_armed <= 1'b0;
      r_shot  <= 1'b0;
      r_flash <= 1'b0;
      r_dry   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_db_q <= w_db;
      if (w_db_valid && !w_db) begin
        r_armed <= 1'b1;
      end
      r_shot <= 1'b0;
      r_dry  <= 1'b0;

      if (r_fsm == FS_IDLE) begin
        r_flash <= 1'b0;
        r_cnt   <= '0;
        if (w_press && w_play) begin
          if (!no_shots_left) begin
            r_shot <= 1'b1;
            r_fsm  <= FS_FLASH;
            r_busy <= 1'b1;
          end else begin
            r_dry  <= 1'b1;
          end
        end
      end else if (!w_play) begin
        // Leaving play aborts any shot sequence immediately
        r_fsm   <= FS_IDLE;
        r_cnt   <= '0;
        r_flash <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_fsm)
          FS_FLASH: begin
            // First FLASH cycle carries the shot pulse; flash window follows
            if (!r_flash) begin
              r_flash <= 1'b1;
              r_cnt   <= '0;
            end else if (r_cnt == c_FLASH_LAST) begin
              r_flash <= 1'b0;
              r_cnt   <= '0;
              r_fsm   <= FS_COOLDOWN;
            end else if (r_cnt != c_CNT_SAT) begin
              r_cnt <= r_cnt + CW'(1);
            end
          end

          FS_COOLDOWN: begin
            if (r_cnt == c_COOL_LAST) begin
              r_cnt <= '0;
`ifdef TRIGGER_AUTO_FIRE_EN
              if (w_db && !no_shots_left) begin
                r_shot <= 1'b1;
                r_fsm  <= FS_FLASH;
              end else if (w_db) begin
                r_dry  <= 1'b1;
                r_fsm  <= FS_RELEASE_WAIT;
              end else begin
                r_fsm  <= FS_IDLE;
                r_busy <= 1'b0;
              end
`else
              if (w_db) begin
                r_fsm  <= FS_RELEASE_WAIT;
              end else begin
                r_fsm  <= FS_IDLE;
                r_busy <= 1'b0;
              end
`endif
            end else if (r_cnt != c_CNT_SAT) begin
              r_cnt <= r_cnt + CW'(1);
            end
          end

          FS_RELEASE_WAIT: begin
            if (!w_db) begin
              r_fsm  <= FS_IDLE;
              r_busy <= 1'b0;
            end
          end

          default: begin
            r_fsm  <= FS_IDLE;
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign shot         = r_shot;
  assign flash_active = r_flash;
  assign dry_fire     = r_dry;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_trigger_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_trigger_ctrl                                        |
// | Description : Directed self-checking bench for trigger_ctrl with     |
// |               DEBOUNCE=4, FLASH=8, COOLDOWN=16. Cycle index i counts |
// |               rising edges after the last trigger_n change; a clean  |
// |               press gives shot at i=7, flash at i=8..15, cooldown    |
// |               i=16..31.                                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_trigger_ctrl;

  localparam bit AUTO =
`ifdef TRIGGER_AUTO_FIRE_EN
    1'b1;
`else
    1'b0;
`endif

  logic       Clk;
  logic       Reset;
  logic       trigger_n;
  logic [2:0] gstate;
  logic       no_shots_left;
  logic       shot;
  logic       flash_active;
  logic       dry_fire;
  logic       busy;

  int errors;
  int checks;

  trigger_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .FLASH_CYCLES    (8),
    .COOLDOWN_CYCLES (16)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .trigger_n     (trigger_n),
    .state         (gstate),
    .no_shots_left (no_shots_left),
    .shot          (shot),
    .flash_active  (flash_active),
    .dry_fire      (dry_fire),
    .busy          (busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    steps(3);
    checks++; if (shot !== 1'b0)         begin errors++; $display("FAIL reset_shot: got %b want 0", shot); end
    checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL reset_flash: got %b want 0", flash_active); end
    checks++; if (dry_fire !== 1'b0)     begin errors++; $display("FAIL reset_dry: got %b want 0", dry_fire); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    Reset = 1'b0;
    steps(12);
  endtask

  task automatic test_single_shot();
    logic es, ef, eb;
    trigger_n = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      es = (i == 7) || (AUTO && i == 32);
      ef = (i >= 8 && i <= 15);
      eb = (i >= 7);
      checks++; if (shot !== es)         begin errors++; $display("FAIL single_shot i=%0d: got %b want %b", i, shot, es); end
      checks++; if (flash_active !== ef) begin errors++; $display("FAIL single_flash i=%0d: got %b want %b", i, flash_active, ef); end
      checks++; if (busy !== eb)         begin errors++; $display("FAIL single_busy i=%0d: got %b want %b", i, busy, eb); end
    end
    trigger_n = 1'b1;
`ifndef TRIGGER_AUTO_FIRE_EN
    for (int j = 1; j <= 10; j++) begin
      step();
      eb = (j < 7);
      checks++; if (busy !== eb) begin errors++; $display("FAIL release_busy j=%0d: got %b want %b", j, busy, eb); end
    end
`else
    steps(60);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b want 0", busy); end
`endif
    steps(4);
  endtask

  task automatic test_bounce();
    logic es;
    for (int k = 0; k < 10; k++) begin
      trigger_n = k[0];
      for (int c = 0; c < 2; c++) begin
        step();
        checks++; if (shot !== 1'b0) begin errors++; $display("FAIL bounce_shot k=%0d: got %b want 0", k, shot); end
      end
    end
    trigger_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      es = (i == 7);
      checks++; if (shot !== es) begin errors++; $display("FAIL bounce_final i=%0d: got %b want %b", i, shot, es); end
    end
    trigger_n = 1'b1;
    steps(60);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bounce_idle: got %b want 0", busy); end
  endtask

  task automatic test_dry_fire();
    logic ed;
    no_shots_left = 1'b1;
    trigger_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      ed = (i == 7);
      checks++; if (dry_fire !== ed)       begin errors++; $display("FAIL dry_pulse i=%0d: got %b want %b", i, dry_fire, ed); end
      checks++; if (shot !== 1'b0)         begin errors++; $display("FAIL dry_shot i=%0d: got %b want 0", i, shot); end
      checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL dry_flash i=%0d: got %b want 0", i, flash_active); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL dry_busy i=%0d: got %b want 0", i, busy); end
    end
    trigger_n = 1'b1;
    steps(12);
    no_shots_left = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    trigger_n = 1'b0;
    steps(7);
    checks++; if (shot !== 1'b1) begin errors++; $display("FAIL abort_shot: got %b want 1", shot); end
    steps(4);
    checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL abort_flash_before: got %b want 1", flash_active); end
    gstate = 3'd0;
    step();
    checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL abort_flash_after: got %b want 0", flash_active); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (shot) n++;
    end
    gstate = 3'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (shot) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL abort_no_more_shots: got %0d want 0", n); end
    trigger_n = 1'b1;
    steps(12);
  endtask

  task automatic test_back_to_back();
    int  n;
    logic es;
    n = 0;
    trigger_n = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      step();
      es = (i == 7) || (i == 41);
      if (shot) n++;
      checks++; if (shot !== es) begin errors++; $display("FAIL b2b_shot i=%0d: got %b want %b", i, shot, es); end
      if (i == 8 || i == 24 || i == 45) trigger_n = 1'b1;
      if (i == 15 || i == 34)           trigger_n = 1'b0;
    end
    checks++; if (n !== 2)       begin errors++; $display("FAIL b2b_count: got %0d want 2", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_auto_fire();
    int  n, exp_n;
    logic es;
    n = 0;
    exp_n = AUTO ? 4 : 1;
    trigger_n = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step();
      es = AUTO ? (i >= 7 && ((i - 7) % 25) == 0) : (i == 7);
      if (shot) n++;
      checks++; if (shot !== es) begin errors++; $display("FAIL auto_shot i=%0d: got %b want %b", i, shot, es); end
    end
    checks++; if (n !== exp_n) begin errors++; $display("FAIL auto_count: got %0d want %0d", n, exp_n); end
    trigger_n = 1'b1;
    steps(60);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL auto_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_midop();
    int  n;
    logic es;
    trigger_n = 1'b0;
    steps(10);
    Reset = 1'b1;
    step();
    checks++; if (shot !== 1'b0)         begin errors++; $display("FAIL midrst_shot: got %b want 0", shot); end
    checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL midrst_flash: got %b want 0", flash_active); end
    checks++; if (dry_fire !== 1'b0)     begin errors++; $display("FAIL midrst_dry: got %b want 0", dry_fire); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    Reset = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (shot) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL midrst_held_shots: got %0d want 0", n); end
    trigger_n = 1'b1;
    steps(12);
    trigger_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      es = (i == 7);
      checks++; if (shot !== es) begin errors++; $display("FAIL midrst_repress i=%0d: got %b want %b", i, shot, es); end
    end
    trigger_n = 1'b1;
    steps(60);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    Reset         = 1'b1;
    trigger_n     = 1'b1;
    gstate        = 3'd1;
    no_shots_left = 1'b0;
    @(negedge Clk);
    test_reset();
    test_single_shot();
    test_bounce();
    test_dry_fire();
    test_abort();
    test_back_to_back();
    test_auto_fire();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
